// File: rtl/wb_uart_slave.sv
// Wishbone classic responder for the UART data/status words: small TX/RX byte
// FIFOs feeding an 8N1 serial transmitter and a mid-bit sampling receiver.
module wb_uart_slave #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        rx_irq_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          req, is_stat, tx_push_req, rx_pop, stat_rd;
    logic [31:0]   rdata;
    logic          overrun, frame_err;
    logic          unused_bits;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [AW:0]   tx_count;
    logic          tx_empty, tx_full, tx_push, tx_pop, tx_idle;
    state_t        tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [AW:0]   rx_count;
    logic          rx_empty, rx_full, rx_push, rx_do_push, rx_do_pop;
    logic          rx_stop_sample, fe_set, ov_set;
    logic [1:0]    rx_sync;
    logic          rx_bit;
    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit_idx;
    logic [7:0]    rx_shift;

    assign unused_bits = ^{wb_adr_i[31:3], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

    // The ~ack term makes a held strobe re-acknowledge only every second cycle.
    assign req         = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign is_stat     = wb_adr_i[2];
    assign tx_push_req = req & wb_we_i & ~is_stat & wb_sel_i[0];
    assign rx_pop      = req & ~wb_we_i & ~is_stat;
    assign stat_rd     = req & ~wb_we_i & is_stat;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_pop   = ~tx_empty & ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == LAST));
    assign tx_push  = tx_push_req & (~tx_full | tx_pop);
    assign tx_idle  = tx_empty & (tx_state == S_IDLE);

    assign rx_empty       = (rx_count == '0);
    assign rx_full        = (rx_count == FULL_CNT);
    assign rx_bit         = rx_sync[1];
    assign rx_stop_sample = (rx_state == S_STOP) && (rx_cnt == LAST);
    assign rx_push        = rx_stop_sample & rx_bit;
    assign fe_set         = rx_stop_sample & ~rx_bit;
    assign rx_do_pop      = rx_pop & ~rx_empty;
    assign rx_do_push     = rx_push & (~rx_full | rx_do_pop);
    assign ov_set         = rx_push & rx_full & ~rx_do_pop;
    assign rx_irq_o       = ~rx_empty;

    // NOTE: every path assigns rdata a default first so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (is_stat)
            rdata = {27'b0, frame_err, overrun, tx_idle, ~rx_empty, ~tx_full};
        else if (!rx_empty)
            rdata = {24'b0, rx_mem[rx_rp]};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wb_ack_o  <= req;
            wb_dat_o  <= (req & ~wb_we_i) ? rdata : '0;
            overrun   <= ov_set | (overrun & ~stat_rd);
            frame_err <= fe_set | (frame_err & ~stat_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            if (rx_do_push) rx_wp <= rx_wp + 1'b1;
            if (rx_do_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_do_push, rx_do_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wp] <= wb_dat_i[7:0];
        if (rx_do_push) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    uart_txd <= 1'b1;
                    if (!tx_empty) begin
                        tx_shift <= tx_mem[tx_rp];
                        uart_txd <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt   <= '0;
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            uart_txd <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit when more bytes wait.
                        if (!tx_empty) begin
                            tx_shift <= tx_mem[tx_rp];
                            uart_txd <= 1'b0;
                            tx_state <= S_START;
                        end else tx_state <= S_IDLE;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync    <= 2'b11;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            case (rx_state)
                S_IDLE: begin
                    if (!rx_bit) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        rx_state   <= rx_bit ? S_IDLE : S_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_bit, rx_shift[7:1]};
                        if (rx_bit_idx == 3'd7) rx_state <= S_STOP;
                        else rx_bit_idx <= rx_bit_idx + 1'b1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                S_STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule
